// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and
// the default datapath width.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_md_datapath.sv
// Iterative magnitude datapath: shift-add multiply and restoring divide sharing
// one 2*WIDTH accumulator (upper = partial product / remainder).
module md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH:0]       a_mag,
    input  logic [WIDTH:0]       b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     opnd_q;
    logic               div_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_next;

    // Operands are magnitudes, so their top bit is zero except in the divide
    // compare; a borrow out of the subtract (diff msb) means rem_sh < divisor.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? opnd_q : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - opnd_q;
        acc_next = acc_q;
        if (div_q) begin
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else if (load) begin
            acc_q  <= {{WIDTH{1'b0}}, (is_div ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0])};
            opnd_q <= is_div ? b_mag : a_mag;
            div_q  <= is_div;
        end else if (step) begin
            acc_q  <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: IDLE -> CALC (WIDTH steps)
// -> FIX (sign correction and HI/LO write), with MTHI/MTLO and flush.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state_q, state_d;
    md_op_t             op_in, op_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_a_q, neg_b_q, b_zero_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               load, step, fix_wr, mt_hi, mt_lo;
    logic               op_signed, op_div;
    logic [WIDTH:0]     a_ext, b_ext, a_abs, b_abs;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    assign op_in     = md_op_t'(op);
    assign op_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign op_div    = (op_in == MD_DIV)  || (op_in == MD_DIVU);
    assign a_ext     = {op_signed & reg_a[WIDTH-1], reg_a};
    assign b_ext     = {op_signed & reg_b[WIDTH-1], reg_b};
    assign a_abs     = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_abs     = b_ext[WIDTH] ? -b_ext : b_ext;

    md_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (op_div),
        .a_mag  (a_abs),
        .b_mag  (b_abs),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix_wr  = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_in)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            load    = 1'b1;
                            state_d = CALC;
                        end
                        MD_MTHI: mt_hi = 1'b1;
                        MD_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                fix_wr  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            step    = 1'b0;
            fix_wr  = 1'b0;
        end
    end

    always_comb begin
        prod   = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo    = (neg_a_q ^ neg_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_q == MD_DIV || op_q == MD_DIVU) begin
            res_hi = b_zero_q ? a_raw_q : rem;
            res_lo = b_zero_q ? '1 : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MULT;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= fix_wr;
            if (load) begin
                op_q     <= op_in;
                cnt_q    <= '0;
                neg_a_q  <= a_ext[WIDTH];
                neg_b_q  <= b_ext[WIDTH];
                b_zero_q <= (reg_b == '0);
                a_raw_q  <= reg_a;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (mt_hi) hi <= reg_a;
            if (mt_lo) lo <= reg_a;
            if (fix_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at start,
// compared when done pulses; handshake, flush and reset cases checked inline.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] reg_a = '0;
    logic [31:0] reg_b = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] popped;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .reg_a (reg_a),
        .reg_b (reg_b),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int     q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MD_MULT:  begin p = sa * sb; return p; end
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            MD_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check_eq("done_without_request", 64'(sb_q.size()), 64'd1);
            end else begin
                popped = sb_q.pop_front();
                check_eq("result_hilo", {hi, lo}, popped);
            end
        end
    end

    // Caller is at a negedge; drives one request and waits for its completion.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic fl, input string tag);
        logic [63:0] e;
        int k, nb;
        op = o; reg_a = a; reg_b = b; start = 1'b1; flush = fl;
        if (o <= 3'd3) begin
            e = model(o, a, b);
            sb_q.push_back(e);
            {m_hi, m_lo} = e;
        end else if (o == MD_MTHI) m_hi = a;
        else if (o == MD_MTLO) m_lo = a;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        if (o <= 3'd3) begin
            k = 0; nb = 0;
            while (k < 60) begin
                @(negedge clk);
                if (done) break;
                if (busy) nb++;
                k++;
            end
            check_eq($sformatf("%s_latency", tag), 64'(k), 64'd33);
            check_eq($sformatf("%s_busy_cycles", tag), 64'(nb), 64'd33);
            check_eq($sformatf("%s_busy_at_done", tag), 64'(busy), 64'd0);
        end else begin
            @(negedge clk);
            check_eq($sformatf("%s_hilo", tag), {hi, lo}, {m_hi, m_lo});
            check_eq($sformatf("%s_no_done", tag), 64'(done), 64'd0);
            check_eq($sformatf("%s_no_busy", tag), 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #12;
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        check_eq("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mult_neg");
        check_eq("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
        check_eq("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, "divu_zero");
        check_eq("divu_zero_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check_eq("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(MD_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_zero_neg");
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
        run_op(MD_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, "div_pos_neg");
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_one");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
            run_op(3'($urandom_range(0, 3)), ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        // Flush mid-operation with ignored starts while busy.
        run_op(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");
        op = MD_MULTU; reg_a = 32'hDEAD_BEEF; reg_b = 32'h1234_5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        op = MD_MTHI; reg_a = 32'h1234_5678; start = 1'b1;
        @(posedge clk);
        #1 op = MD_DIVU; reg_a = 32'd9; reg_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});
        check_eq("flush_still_idle", 64'(busy), 64'd0);

        run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, "mthi_idle");
        check_eq("mthi_const", 64'(hi), 64'h1234_5678);

        run_op(MD_DIVU, 32'd100, 32'd7, 1'b1, "flush_idle_start");

        op = 3'd6; reg_a = 32'h5555_5555; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("undef_op_hilo", {hi, lo}, {m_hi, m_lo});
        check_eq("undef_op_busy", 64'(busy), 64'd0);

        op = MD_MULT; reg_a = 32'd123; reg_b = 32'd456; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midcalc_reset_hilo", {hi, lo}, 64'd0);
        check_eq("midcalc_reset_busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post_reset_hilo", {hi, lo}, 64'd0);
        check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS datapath; owns the architectural HI/LO registers.
- Successor to the combinational MULT/MULTU path in the ALU. Generalised to WIDTH. Adds signed and unsigned divide, MTHI/MTLO writes, a start/busy/done handshake and flush.
- Sits beside the ALU. The controller stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  3  md_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- reg_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- reg_b  input  WIDTH  multiplier / divisor
- flush  input  1  synchronous abort of an in-flight operation
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse; hi/lo just updated by mult/div

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0.
  - State IDLE; iteration counter=0.
  - Reset mid-operation discards the operation with no hi/lo update.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 with MD_MTHI at edge E0: hi<=reg_a. No busy, no done.
  - start=1 with MD_MTLO at edge E0: lo<=reg_a. No busy, no done.
  - start=1 with a mult/div op at edge E0:
    - Latch op.
    - For signed ops, latch abs(reg_a), abs(reg_b) and the sign flags.
    - Counter<=0, busy<=1, state CALC.
  - Undefined op codes are ignored.
- CALC:
  - One iteration per cycle for exactly WIDTH edges.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; one quotient bit per edge.
  - After WIDTH iterations, go to FIX.
- FIX (one edge):
  - Apply signs: product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign.
  - Write hi/lo, done<=1, busy<=0, state IDLE.
- Latency: start edge E0; hi/lo and done updated at edge E(WIDTH+1). done is high for exactly one cycle.
  - busy is high in the cycles after edges E0..E(WIDTH); it drops at the same edge done rises.
- Back-to-back: start is accepted in the done cycle, because busy=0.
- start while busy=1 is ignored, including MTHI/MTLO. The controller must hold the request.
- flush=1 while busy:
  - Next edge returns to IDLE, busy<=0.
  - hi/lo unchanged, done stays 0.
  - flush has priority over the FIX write.
  - flush in IDLE has no effect; a start in the same cycle is still accepted.
- Divide by zero (reg_b=0): lo=all-ones, hi=dividend (raw reg_a). Normal latency.
- Signed overflow (DIV of most-negative by -1): lo=most-negative, hi=0.
- Width rules:
  - Product is the full 2*WIDTH: hi=upper, lo=lower.
  - Operand absolute values use WIDTH+1-bit intermediates, so the most-negative operand is handled correctly.
- hi/lo change only on MTHI/MTLO acceptance, FIX, or reset.

Decomposition:
- Shared package (alongside the ALU opsel constants) holds:
  - md_op_t enum;
  - md_state_t enum (IDLE, CALC, FIX);
  - shared WIDTH default.
- One natural sub-module: md_datapath.
  - Holds the accumulator/remainder registers and the per-iteration add/subtract step.
  - Controlled by the FSM in mult_div_unit; the FSM owns the counter, handshake and HI/LO.

Test Plan:
- MD_MULTU, reg_a=0xFFFFFFFF, reg_b=0xFFFFFFFF -> done after 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MD_MULT, reg_a=0xFFFFFFFE (-2), reg_b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MD_DIV, reg_a=0xFFFFFFF9 (-7), reg_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). MD_DIVU, reg_a=7, reg_b=0 -> lo=0xFFFFFFFF, hi=7.
- MD_DIV, reg_a=0x80000000, reg_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MD_MULTU started, flush at cycle 10 -> busy=0 next cycle, done never asserts, hi/lo keep prior values. A second start during busy is ignored.
- MD_MTHI 0x12345678 while busy -> ignored. Same MD_MTHI in IDLE -> hi=0x12345678 next edge, no done. rst_n low mid-CALC -> hi=lo=0, busy=0 immediately.
